pair_judge: RTL

- Game-logic end of the square-status interface: the cursor block drives the cursor index and highlight, and this block owns the reveal/match state of every square.
- On a select press it reveals the square under the cursor and, once two are revealed, compares their colours.
- A matched pair is locked as matched. A mismatched pair is shown for a fixed hold time, then hidden again.
- Status is fed back to the cursor block (skip logic) and to the VGA renderer.

---
 rtl/pair_judge_pkg.sv | 19 +
 rtl/pair_judge_if.sv | 36 +++
 rtl/button_edge.sv | 25 ++
 rtl/pair_judge.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pair_judge_pkg.sv
// rtl/pair_judge_pkg.sv - shared square status codes, FSM states and default hold time
package pair_judge_pkg;

    localparam logic [1:0] ST_HIDDEN   = 2'b00;
    localparam logic [1:0] ST_CURSOR   = 2'b01;
    localparam logic [1:0] ST_REVEALED = 2'b10;
    localparam logic [1:0] ST_MATCHED  = 2'b11;

    localparam int DEFAULT_HOLD_CYCLES = 25000000;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        COMPARE,
        SHOW,
        DONE
    } state_t;

endpackage

// File: rtl/pair_judge_if.sv
// rtl/pair_judge_if.sv - square-status interface between cursor block (master) and pair_judge (slave)
interface pair_judge_if #(
    parameter int N_SQUARES = 4,
    parameter int COLOR_W   = 2
);
    logic [2:0]                   cursor;
    logic                         select_button;
    logic                         clear;
    logic [N_SQUARES*COLOR_W-1:0] colors;
    logic [2*N_SQUARES-1:0]       status;
    logic [2:0]                   match;
    logic                         busy;
    logic                         mismatch;
    logic                         game_over;
`ifdef MISS_COUNTER_EN
    logic [7:0]                   misses;

    modport master (
        output cursor, select_button, clear, colors,
        input  status, match, busy, mismatch, game_over, misses
    );
    modport slave (
        input  cursor, select_button, clear, colors,
        output status, match, busy, mismatch, game_over, misses
    );
`else
    modport master (
        output cursor, select_button, clear, colors,
        input  status, match, busy, mismatch, game_over
    );
    modport slave (
        input  cursor, select_button, clear, colors,
        output status, match, busy, mismatch, game_over
    );
`endif
endinterface

// File: rtl/button_edge.sv
// rtl/button_edge.sv - two-flop synchroniser plus rising-edge pulse for push buttons and switches
module button_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_hist;
endmodule

// File: rtl/pair_judge.sv
// rtl/pair_judge.sv - reveal/match game logic for the squares; MISS_COUNTER_EN adds a saturating miss counter
module pair_judge
    import pair_judge_pkg::*;
#(
    parameter int N_SQUARES   = 4,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int COLOR_W     = 2
) (
    input  logic        clk25MHz,
    input  logic        rst,
    pair_judge_if.slave bus
);
    localparam int               IDX_W    = $clog2(N_SQUARES);
    localparam int               TMR_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [3:0]       N_L      = 4'(N_SQUARES);
    localparam logic [2:0]       PAIRS    = 3'(N_SQUARES / 2);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

    state_t             r_state;
    logic [1:0]         r_status [N_SQUARES];
    logic [IDX_W-1:0]   r_first_idx;
    logic [IDX_W-1:0]   r_second_idx;
    logic [TMR_W-1:0]   r_timer;
    logic [2:0]         r_match;
    logic               r_busy;
    logic               r_game_over;
    logic               w_sel_pulse;
    logic               w_press_ok;
    logic               w_colors_eq;
    logic [IDX_W-1:0]   w_idx;
    logic [COLOR_W-1:0] w_color [N_SQUARES];

    button_edge u_select (
        .i_clk   (clk25MHz),
        .i_rst_n (rst),
        .i_btn   (bus.select_button),
        .o_pulse (w_sel_pulse)
    );

    always_comb begin
        for (int i = 0; i < N_SQUARES; i++) begin
            w_color[i] = bus.colors[i*COLOR_W +: COLOR_W];
        end
    end

    assign w_idx       = bus.cursor[IDX_W-1:0];
    assign w_press_ok  = w_sel_pulse && ({1'b0, bus.cursor} < N_L) && (r_status[w_idx] == ST_HIDDEN);
    assign w_colors_eq = (w_color[r_first_idx] == w_color[r_second_idx]);

    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_first_idx  <= '0;
            r_second_idx <= '0;
            r_timer      <= '0;
            r_match      <= '0;
            r_busy       <= 1'b0;
            r_game_over  <= 1'b0;
            for (int i = 0; i < N_SQUARES; i++) r_status[i] <= ST_HIDDEN;
        end else if (bus.clear) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_match     <= '0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
            for (int i = 0; i < N_SQUARES; i++) r_status[i] <= ST_HIDDEN;
        end else begin
            case (r_state)
                IDLE: if (w_press_ok) begin
                    r_status[w_idx] <= ST_REVEALED;
                    r_first_idx     <= w_idx;
                    r_state         <= FIRST;
                end
                FIRST: if (w_press_ok) begin
                    r_status[w_idx] <= ST_REVEALED;
                    r_second_idx    <= w_idx;
                    r_state         <= COMPARE;
                    r_busy          <= 1'b1;
                end
                COMPARE: if (w_colors_eq) begin
                    r_status[r_first_idx]  <= ST_MATCHED;
                    r_status[r_second_idx] <= ST_MATCHED;
                    r_match                <= r_match + 3'd1;
                    r_busy                 <= 1'b0;
                    if (r_match + 3'd1 == PAIRS) begin
                        r_state     <= DONE;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end else begin
                    r_timer <= TMR_LOAD;
                    r_state <= SHOW;
                end
                // presses in SHOW are dropped: the FSM simply never looks at them here
                SHOW: if (r_timer == '0) begin
                    r_status[r_first_idx]  <= ST_HIDDEN;
                    r_status[r_second_idx] <= ST_HIDDEN;
                    r_busy                 <= 1'b0;
                    r_state                <= IDLE;
                end else begin
                    r_timer <= r_timer - TMR_W'(1);
                end
                DONE: r_game_over <= 1'b1;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.status = '0;
        for (int i = 0; i < N_SQUARES; i++) begin
            bus.status[2*i +: 2] = r_status[i];
        end
    end

    assign bus.match     = r_match;
    assign bus.busy      = r_busy;
    assign bus.game_over = r_game_over;
    assign bus.mismatch  = (r_state == COMPARE) && !w_colors_eq;

`ifdef MISS_COUNTER_EN
    logic [7:0] r_misses;

    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            r_misses <= '0;
        end else if (bus.clear) begin
            r_misses <= '0;
        end else if (bus.mismatch && (r_misses != 8'hFF)) begin
            r_misses <= r_misses + 8'd1;
        end
    end

    assign bus.misses = r_misses;
`endif
endmodule
